// File: rtl/riscv_pkg.sv
// Shared RV32M encodings and the divider FSM state type.
// Both the top level and its testbench import this package.
package riscv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One radix-2 restoring division step on a packed {remainder, quotient} accumulator.
// The dividend is shifted in from the quotient half, one bit per step.
module div_restoring_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // A borrow out of the trial subtraction means the divisor did not fit, so the shifted remainder is restored.
    always_comb begin
        shifted = acc_in[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, divisor};
        if (diff[WIDTH]) begin
            acc_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
        end else begin
            acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: one op in flight, one quotient bit per cycle.
// Divide-by-zero and signed overflow skip the iteration and go straight to the result cycle.
module div_seq_unit
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_op1,
    input  logic [WIDTH-1:0] req_op2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [TAG_W-1:0] resp_tag
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic [2:0]       funct_q;
    logic [TAG_W-1:0] tag_q;
    logic [WIDTH-1:0] divisor_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic             neg_quo;
    logic             neg_rem;

    logic [2:0]       funct_n;
    logic             is_signed;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] result;

    assign req_ready = (state == S_IDLE);

    // Bit 2 of funct3 is forced high so the 000..011 aliases decode like the real MULDIV encodings.
    always_comb begin
        funct_n   = req_funct3 | 3'b100;
        is_signed = (funct_n == FUNCT3_DIV) || (funct_n == FUNCT3_REM);
        sign_a    = is_signed && req_op1[WIDTH-1];
        sign_b    = is_signed && req_op2[WIDTH-1];
        abs_a     = sign_a ? -req_op1 : req_op1;
        abs_b     = sign_b ? -req_op2 : req_op2;
        div_zero  = (req_op2 == '0);
        overflow  = is_signed && (req_op1 == MIN_INT) && (req_op2 == '1);
    end

    div_restoring_step #(.WIDTH(WIDTH)) u_step (
        .acc_in  (acc),
        .divisor (divisor_q),
        .acc_out (acc_next)
    );

    always_comb begin
        quo    = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        result = ((funct_q == FUNCT3_REM) || (funct_q == FUNCT3_REMU)) ?
                 (neg_rem ? -rem : rem) : (neg_quo ? -quo : quo);
    end

    // Bypass ops preload the accumulator with their architectural {rem, quo} so DONE fixes up every op the same way.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            funct_q    <= '0;
            tag_q      <= '0;
            divisor_q  <= '0;
            acc        <= '0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
        end else if (flush) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        funct_q   <= funct_n;
                        tag_q     <= req_tag;
                        divisor_q <= abs_b;
                        count     <= '0;
                        if (div_zero) begin
                            acc     <= {req_op1, {WIDTH{1'b1}}};
                            neg_quo <= 1'b0;
                            neg_rem <= 1'b0;
                            state   <= S_DONE;
                        end else if (overflow) begin
                            acc     <= {{WIDTH{1'b0}}, MIN_INT};
                            neg_quo <= 1'b0;
                            neg_rem <= 1'b0;
                            state   <= S_DONE;
                        end else begin
                            acc     <= {{WIDTH{1'b0}}, abs_a};
                            neg_quo <= sign_a ^ sign_b;
                            neg_rem <= sign_a;
                            state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc   <= acc_next;
                    count <= count + CNT_W'(1);
                    if (count == LAST_COUNT) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                        resp_data  <= result;
                        resp_tag   <= tag_q;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_unit.sv
// Scoreboard bench for div_seq_unit: directed ops push expected results, a monitor checks each handshake.
// Latency, stall, flush and reset behaviour are checked inline by the stimulus process.
module tb_div_seq_unit;
    import riscv_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_op1;
    logic [WIDTH-1:0] req_op2;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic [TAG_W-1:0] resp_tag;

    exp_t sb[$];
    exp_t popped;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    div_seq_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_tag    (req_tag),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every completed handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && !flush && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_resp: got data 0x%08h tag %0d, expected no response", resp_data, resp_tag);
            end else begin
                popped = sb.pop_front();
                checkOutput("resp_data", resp_data, popped.data);
                checkOutput("resp_tag", {28'd0, resp_tag}, {28'd0, popped.tag});
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] funct3, input logic [WIDTH-1:0] op1,
                                 input logic [WIDTH-1:0] op2, input logic [TAG_W-1:0] tag,
                                 input logic [WIDTH-1:0] expected, input bit push);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_ready_timeout: got 0, expected 1");
        end
        req_valid  = 1'b1;
        req_funct3 = funct3;
        req_op1    = op1;
        req_op2    = op2;
        req_tag    = tag;
        if (push) sb.push_back('{data: expected, tag: tag});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic waitResponse(input string name, input int exp_lat);
        int n = 0;
        int m = 0;
        while (!resp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({name, "_latency"}, 32'(n), 32'(exp_lat));
        while (resp_ready && resp_valid && m < 100) begin
            @(posedge clk); #1;
            m++;
        end
    endtask

    task automatic watchQuiet(input string name, input int cycles);
        int bad = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (resp_valid) bad++;
        end
        checkOutput(name, 32'(bad), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_funct3 = 3'b000;
        req_op1    = '0;
        req_op2    = '0;
        req_tag    = '0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("reset_resp_data", resp_data, 32'd0);
        checkOutput("reset_resp_tag", {28'd0, resp_tag}, 32'd0);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);

        // Unsigned basics and full-length latency
        applyStimulus(FUNCT3_DIVU, 32'd100, 32'd7, 4'd3, 32'd14, 1'b1);
        waitResponse("divu_100_7", 33);
        applyStimulus(FUNCT3_REMU, 32'd100, 32'd7, 4'd4, 32'd2, 1'b1);
        waitResponse("remu_100_7", 33);
        applyStimulus(FUNCT3_DIVU, 32'hFFFF_FFFF, 32'd2, 4'd1, 32'h7FFF_FFFF, 1'b1);
        waitResponse("divu_max_2", 33);

        // Signed sign rules
        applyStimulus(FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 4'd5, 32'hFFFF_FFFD, 1'b1);
        waitResponse("div_m7_2", 33);
        applyStimulus(FUNCT3_REM, 32'hFFFF_FFF9, 32'd2, 4'd6, 32'hFFFF_FFFF, 1'b1);
        waitResponse("rem_m7_2", 33);
        applyStimulus(FUNCT3_DIV, 32'd7, 32'hFFFF_FFFE, 4'd7, 32'hFFFF_FFFD, 1'b1);
        waitResponse("div_7_m2", 33);
        applyStimulus(3'b010, 32'd7, 32'hFFFF_FFFE, 4'd8, 32'd1, 1'b1);
        waitResponse("rem_7_m2_alias", 33);
        applyStimulus(FUNCT3_DIV, 32'h8000_0000, 32'd2, 4'd9, 32'hC000_0000, 1'b1);
        waitResponse("div_min_2", 33);

        // Bypass cases answer one edge after accept
        applyStimulus(FUNCT3_DIV, 32'd5, 32'd0, 4'd10, 32'hFFFF_FFFF, 1'b1);
        waitResponse("div_5_0", 1);
        applyStimulus(FUNCT3_REMU, 32'd5, 32'd0, 4'd11, 32'd5, 1'b1);
        waitResponse("remu_5_0", 1);
        applyStimulus(FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd12, 32'h8000_0000, 1'b1);
        waitResponse("div_ovf", 1);
        applyStimulus(FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd13, 32'd0, 1'b1);
        waitResponse("rem_ovf", 1);

        // Writeback stall holds the result
        resp_ready = 1'b0;
        applyStimulus(FUNCT3_DIVU, 32'd50, 32'd5, 4'd14, 32'd10, 1'b1);
        waitResponse("stall_op", 33);
        repeat (5) begin
            @(posedge clk); #1;
            checkOutput("stall_valid", {31'd0, resp_valid}, 32'd1);
            checkOutput("stall_data", resp_data, 32'd10);
            checkOutput("stall_tag", {28'd0, resp_tag}, 32'd14);
            checkOutput("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("stall_release_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("stall_release_ready", {31'd0, req_ready}, 32'd1);

        // Flush in the middle of iteration
        applyStimulus(FUNCT3_DIVU, 32'd1000, 32'd3, 4'd5, 32'd0, 1'b0);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("flush_resp_valid", {31'd0, resp_valid}, 32'd0);
        watchQuiet("flush_no_resp", 40);
        applyStimulus(FUNCT3_DIVU, 32'd9, 32'd3, 4'd2, 32'd3, 1'b1);
        waitResponse("divu_9_3", 33);

        // Reset mid-iteration, then flush racing an offer in IDLE
        applyStimulus(FUNCT3_DIV, 32'd100, 32'd7, 4'd6, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_mid_data", resp_data, 32'd0);
        checkOutput("rst_mid_tag", {28'd0, resp_tag}, 32'd0);
        checkOutput("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        flush      = 1'b1;
        req_valid  = 1'b1;
        req_funct3 = FUNCT3_DIVU;
        req_op1    = 32'd77;
        req_op2    = 32'd7;
        req_tag    = 4'd9;
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        checkOutput("flush_offer_req_ready", {31'd0, req_ready}, 32'd1);
        watchQuiet("flush_offer_no_resp", 40);

        // Recovery after reset
        applyStimulus(FUNCT3_DIV, 32'hFFFF_FF9C, 32'd7, 4'd15, 32'hFFFF_FFF2, 1'b1);
        waitResponse("div_m100_7", 33);
        applyStimulus(FUNCT3_REM, 32'hFFFF_FF9C, 32'd7, 4'd0, 32'hFFFF_FFFE, 1'b1);
        waitResponse("rem_m100_7", 33);

        repeat (2) @(posedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
